// File: rtl/dec8b10b_link_sync_ctrl.sv
// -----------------------------------------------------------------------------
// dec8b10b_link_sync_ctrl
//
// Sequencing and word-sync controller for an 8b/10b decoder. After link_en the
// decoder is enabled with its running disparity forced to RD- for FORCE_CYCLES
// cycles. The controller then hunts for K28.5 commas and declares sync after
// ACQ_COMMAS consecutive good commas. In sync, a leaky bad-word counter
// (LOSE_ERRS errors, one forgiven per GOOD_WORDS good words) decides loss of
// sync. Error words seen in ACQ/SYNC are tallied in a saturating counter.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   link_en      controller enable; 0 returns to IDLE
//   err_clr      synchronous clear of err_cnt (wins over increment)
//   dec_valid    decoder word valid
//   dec_dataout  decoded byte
//   dec_kout     decoded word is a K-character
//   dec_kerr     decoder code error
//   dec_rderr    decoder running-disparity error
//   dec_ena      decoder enable
//   dec_rdforce  force decoder running disparity
//   dec_rdin     forced disparity value (always RD-, i.e. 0)
//   sync         link word-synchronised
//   sync_lost    one-cycle pulse on SYNC -> HUNT
//   state        FSM state: IDLE=0 FORCE=1 HUNT=2 ACQ=3 SYNC=4
//   err_cnt      saturating error-word count
// -----------------------------------------------------------------------------
module dec8b10b_link_sync_ctrl #(
   parameter logic [7:0] COMMA        = 8'hBC,
   parameter int         ACQ_COMMAS   = 3,
   parameter int         LOSE_ERRS    = 4,
   parameter int         GOOD_WORDS   = 4,
   parameter int         FORCE_CYCLES = 2,
   parameter int         ERR_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             link_en,
   input  logic             err_clr,
   input  logic             dec_valid,
   input  logic [7:0]       dec_dataout,
   input  logic             dec_kout,
   input  logic             dec_kerr,
   input  logic             dec_rderr,
   output logic             dec_ena,
   output logic             dec_rdforce,
   output logic             dec_rdin,
   output logic             sync,
   output logic             sync_lost,
   output logic [2:0]       state,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FORCE = 3'd1,
      S_HUNT  = 3'd2,
      S_ACQ   = 3'd3,
      S_SYNC  = 3'd4
   } state_t;

   localparam logic [3:0]       ACQ_N   = 4'(ACQ_COMMAS);
   localparam logic [3:0]       LOSE_N  = 4'(LOSE_ERRS);
   localparam logic [3:0]       GOOD_N  = 4'(GOOD_WORDS);
   localparam logic [3:0]       FORCE_N = 4'(FORCE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           state_reg, state_next;
   logic [3:0]       timer_reg, timer_next;
   logic [3:0]       acq_cnt_reg, acq_cnt_next;
   logic [3:0]       bad_cnt_reg, bad_cnt_next;
   logic [3:0]       good_cnt_reg, good_cnt_next;
   logic [ERR_W-1:0] err_cnt_reg;
   logic             err_inc;
   logic             sync_lost_next;

   logic             dec_ena_reg, dec_rdforce_reg, sync_reg, sync_lost_reg;

   // Word classification; all classes are qualified by dec_valid so idle
   // cycles never move a counter.
   logic word_err, word_good, word_comma;
   assign word_err   = dec_valid & (dec_kerr | dec_rderr);
   assign word_good  = dec_valid & ~(dec_kerr | dec_rderr);
   assign word_comma = word_good & dec_kout & (dec_dataout == COMMA);

   always_comb begin
      state_next     = state_reg;
      timer_next     = timer_reg;
      acq_cnt_next   = acq_cnt_reg;
      bad_cnt_next   = bad_cnt_reg;
      good_cnt_next  = good_cnt_reg;
      err_inc        = 1'b0;
      sync_lost_next = 1'b0;

      if (!link_en && state_reg != S_IDLE) begin
         // Disable takes priority over any word-class transition.
         state_next    = S_IDLE;
         timer_next    = '0;
         acq_cnt_next  = '0;
         bad_cnt_next  = '0;
         good_cnt_next = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (link_en) begin
                  state_next = S_FORCE;
                  timer_next = FORCE_N;
               end
            end
            S_FORCE: begin
               if (timer_reg == 4'd0) state_next = S_HUNT;
               else                   timer_next = timer_reg - 4'd1;
            end
            S_HUNT: begin
               if (word_comma) begin
                  if (ACQ_N == 4'd1) begin
                     state_next    = S_SYNC;
                     acq_cnt_next  = '0;
                     bad_cnt_next  = '0;
                     good_cnt_next = '0;
                  end else begin
                     state_next   = S_ACQ;
                     acq_cnt_next = 4'd1;
                  end
               end
            end
            S_ACQ: begin
               if (word_err) begin
                  state_next   = S_HUNT;
                  acq_cnt_next = '0;
                  err_inc      = 1'b1;
               end else if (word_comma) begin
                  if (acq_cnt_reg + 4'd1 == ACQ_N) begin
                     state_next    = S_SYNC;
                     acq_cnt_next  = '0;
                     bad_cnt_next  = '0;
                     good_cnt_next = '0;
                  end else begin
                     acq_cnt_next = acq_cnt_reg + 4'd1;
                  end
               end
            end
            S_SYNC: begin
               if (word_err) begin
                  err_inc       = 1'b1;
                  good_cnt_next = '0;
                  if (bad_cnt_reg + 4'd1 == LOSE_N) begin
                     state_next     = S_HUNT;
                     sync_lost_next = 1'b1;
                     bad_cnt_next   = '0;
                     acq_cnt_next   = '0;
                  end else begin
                     bad_cnt_next = bad_cnt_reg + 4'd1;
                  end
               end else if (word_good) begin
                  // A run of GOOD_WORDS good words forgives one error.
                  if (good_cnt_reg + 4'd1 == GOOD_N) begin
                     good_cnt_next = '0;
                     if (bad_cnt_reg != 4'd0) bad_cnt_next = bad_cnt_reg - 4'd1;
                  end else begin
                     good_cnt_next = good_cnt_reg + 4'd1;
                  end
               end
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= S_IDLE;
         timer_reg    <= '0;
         acq_cnt_reg  <= '0;
         bad_cnt_reg  <= '0;
         good_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         acq_cnt_reg  <= acq_cnt_next;
         bad_cnt_reg  <= bad_cnt_next;
         good_cnt_reg <= good_cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_cnt_reg <= '0;
      end else if (err_clr) begin
         err_cnt_reg <= '0;
      end else if (err_inc && err_cnt_reg != ERR_MAX) begin
         err_cnt_reg <= err_cnt_reg + 1'b1;
      end
   end

   // Outputs are registered from the next state so they change on the same
   // edge that enters the state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dec_ena_reg     <= 1'b0;
         dec_rdforce_reg <= 1'b0;
         sync_reg        <= 1'b0;
         sync_lost_reg   <= 1'b0;
      end else begin
         dec_ena_reg     <= (state_next != S_IDLE);
         dec_rdforce_reg <= (state_next == S_FORCE);
         sync_reg        <= (state_next == S_SYNC);
         sync_lost_reg   <= sync_lost_next;
      end
   end

   assign dec_ena     = dec_ena_reg;
   assign dec_rdforce = dec_rdforce_reg;
   assign dec_rdin    = 1'b0;
   assign sync        = sync_reg;
   assign sync_lost   = sync_lost_reg;
   assign state       = state_reg;
   assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_dec8b10b_link_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dec8b10b_link_sync_ctrl
//
// Directed bench for the link sync controller, built with ERR_W=4 so the
// saturation boundary is reachable. Each stimulus word is applied for one
// clock; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dec8b10b_link_sync_ctrl;

   localparam int ERR_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             link_en;
   logic             err_clr;
   logic             dec_valid;
   logic [7:0]       dec_dataout;
   logic             dec_kout;
   logic             dec_kerr;
   logic             dec_rderr;
   logic             dec_ena;
   logic             dec_rdforce;
   logic             dec_rdin;
   logic             sync;
   logic             sync_lost;
   logic [2:0]       state;
   logic [ERR_W-1:0] err_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dec8b10b_link_sync_ctrl #(
      .COMMA       (8'hBC),
      .ACQ_COMMAS  (3),
      .LOSE_ERRS   (4),
      .GOOD_WORDS  (4),
      .FORCE_CYCLES(2),
      .ERR_W       (ERR_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .link_en    (link_en),
      .err_clr    (err_clr),
      .dec_valid  (dec_valid),
      .dec_dataout(dec_dataout),
      .dec_kout   (dec_kout),
      .dec_kerr   (dec_kerr),
      .dec_rderr  (dec_rderr),
      .dec_ena    (dec_ena),
      .dec_rdforce(dec_rdforce),
      .dec_rdin   (dec_rdin),
      .sync       (sync),
      .sync_lost  (sync_lost),
      .state      (state),
      .err_cnt    (err_cnt)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
         $display("ok   %-14s got=%0d", tag, got);
      end else begin
         $display("FAIL %-14s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Apply one word for one clock, then settle past the edge.
   task automatic word(input logic v, input logic [7:0] d, input logic k,
                       input logic ke, input logic rde);
      dec_valid   = v;
      dec_dataout = d;
      dec_kout    = k;
      dec_kerr    = ke;
      dec_rderr   = rde;
      @(posedge clk);
      #1;
   endtask

   task automatic comma();   word(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0); endtask
   task automatic gap();     word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask
   task automatic data4a();  word(1'b1, 8'h4A, 1'b0, 1'b0, 1'b0); endtask
   task automatic errw();    word(1'b1, 8'h00, 1'b0, 1'b1, 1'b0); endtask
   task automatic rderrw();  word(1'b1, 8'h4A, 1'b0, 1'b0, 1'b1); endtask

   task automatic check_outs(input string tag, input int st, input int ena,
                             input int rdf, input int sy, input int sl);
      check({tag, ".state"}, int'(state), st);
      check({tag, ".ena"},   int'(dec_ena), ena);
      check({tag, ".rdforce"}, int'(dec_rdforce), rdf);
      check({tag, ".sync"},  int'(sync), sy);
      check({tag, ".lost"},  int'(sync_lost), sl);
   endtask

   initial begin
      reset_n = 1'b0; link_en = 1'b0; err_clr = 1'b0;
      dec_valid = 1'b0; dec_dataout = 8'h00; dec_kout = 1'b0;
      dec_kerr = 1'b0; dec_rderr = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_outs("rst", 0, 0, 0, 0, 0);
      check("rst.rdin", int'(dec_rdin), 0);
      check("rst.errcnt", int'(err_cnt), 0);

      // Bring-up: FORCE for exactly two cycles, then HUNT.
      link_en = 1'b1;
      gap();  check_outs("force1", 1, 1, 1, 0, 0);
      check("force1.rdin", int'(dec_rdin), 0);
      gap();  check_outs("force2", 1, 1, 1, 0, 0);
      gap();  check_outs("hunt", 2, 1, 0, 0, 0);

      // Acquisition with gaps and a data word in between.
      comma();  check("acq.c1", int'(state), 3);
      gap();    check("acq.gap", int'(state), 3);
      data4a(); check("acq.data", int'(state), 3);
      comma();  check("acq.c2", int'(state), 3);
      check("acq.c2sync", int'(sync), 0);
      gap();
      comma();  check_outs("insync", 4, 1, 0, 1, 0);

      // Loss of sync: bad 1,2 -> forgiven to 1 -> 2,3,4.
      errw();   check("los.e1cnt", int'(err_cnt), 1);
      rderrw(); check("los.e2cnt", int'(err_cnt), 2);
      repeat (4) data4a();
      check("los.good", int'(state), 4);
      errw();   check("los.e3", int'(state), 4);
      errw();   check("los.e4", int'(state), 4);
      check("los.e4lost", int'(sync_lost), 0);
      errw();   check_outs("lost", 2, 1, 0, 0, 1);
      check("lost.errcnt", int'(err_cnt), 5);
      gap();    check("lost.pulse", int'(sync_lost), 0);

      // Error words in HUNT are not counted.
      errw();   check("hunt.err", int'(err_cnt), 5);
      check("hunt.errst", int'(state), 2);

      // Acquire abort.
      comma(); comma();
      check("abort.acq", int'(state), 3);
      errw();
      check("abort.st", int'(state), 2);
      check("abort.cnt", int'(err_cnt), 6);
      check("abort.sync", int'(sync), 0);

      // Saturation: 20 error words in SYNC (4 per acquisition).
      for (int g = 0; g < 5; g++) begin
         comma(); comma(); comma();
         repeat (4) errw();
      end
      check("sat.cnt", int'(err_cnt), 15);
      check("sat.st", int'(state), 2);
      comma(); errw();
      check("sat.hold", int'(err_cnt), 15);

      // err_clr wins over a same-cycle increment in ACQ.
      comma();
      err_clr = 1'b1;
      errw();
      err_clr = 1'b0;
      check("clr.cnt", int'(err_cnt), 0);
      check("clr.st", int'(state), 2);

      // link_en=0 in SYNC, alongside an error word (disable has priority).
      comma(); comma(); comma();
      errw();
      check("dis.pre", int'(err_cnt), 1);
      link_en = 1'b0;
      errw();
      check_outs("dis", 0, 0, 0, 0, 0);
      check("dis.errcnt", int'(err_cnt), 1);
      gap();   check("dis.lost2", int'(sync_lost), 0);

      // Reset during FORCE.
      link_en = 1'b1;
      gap();   check("rf.force", int'(state), 1);
      reset_n = 1'b0;
      gap();   check_outs("rf", 0, 0, 0, 0, 0);
      check("rf.errcnt", int'(err_cnt), 0);
      reset_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dec8b10b_link_sync_ctrl.md
Name: dec8b10b_link_sync_ctrl

Overview:
- Sequencing controller for the 8b/10b decoder datapath.
- Drives the decoder's `ena`, `rdforce` and `rdin` inputs.
- Monitors the decoder's `valid`, `dataout`, `kout`, `kerr` and `rderr` outputs to acquire and hold word-level link sync on K28.5 commas.
- Reports sync status, loss-of-sync events and a saturating code-error count to the link layer above the decoder.

Parameters:
- COMMA, 8'hBC, decoded K-character used for acquisition (K28.5).
- ACQ_COMMAS, 3, consecutive-good commas required to declare sync (range 1..15).
- LOSE_ERRS, 4, net error words in SYNC that drop sync (range 1..15).
- GOOD_WORDS, 4, consecutive good words in SYNC that forgive one error (range 1..15).
- FORCE_CYCLES, 2, cycles `rdforce` is held after enable (range 1..15).
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- link_en  in  1  controller enable; 0 returns the controller to IDLE.
- err_clr  in  1  synchronous clear of err_cnt.
- dec_valid  in  1  decoder output word valid.
- dec_dataout  in  8  decoded byte.
- dec_kout  in  1  decoded word is a K-character.
- dec_kerr  in  1  decoder code error.
- dec_rderr  in  1  decoder running-disparity error.
- dec_ena  out  1  decoder enable.
- dec_rdforce  out  1  force decoder running disparity.
- dec_rdin  out  1  forced disparity value; always 0, i.e. RD−.
- sync  out  1  link word-synchronised.
- sync_lost  out  1  one-cycle pulse on the SYNC→HUNT transition.
- state  out  3  current FSM state: IDLE=0, FORCE=1, HUNT=2, ACQ=3, SYNC=4.
- err_cnt  out  ERR_W  saturating count of error words.

Behaviour:
- Word classes, evaluated only when dec_valid=1:
  - err word: dec_kerr | dec_rderr.
  - comma: !err & dec_kout & (dec_dataout==COMMA).
  - good: !err.
  - Cycles with dec_valid=0 change no counter and cause no transition, except the link_en and FORCE-timer paths.
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - dec_ena=0, dec_rdforce=0, dec_rdin=0, sync=0, sync_lost=0, err_cnt=0.
  - All internal counters = 0.
  - Reset mid-operation aborts immediately with no pulse.
- All outputs are registered. Every output decode below is the value at the edge that enters the state.
- IDLE:
  - All outputs 0 (err_cnt holds).
  - link_en=1 → FORCE; timer loaded with FORCE_CYCLES−1.
- FORCE:
  - dec_ena=1, dec_rdforce=1, dec_rdin=0.
  - Timer decrements each cycle; at 0 → HUNT, so rdforce is high for exactly FORCE_CYCLES cycles.
  - Decoder outputs are ignored.
- HUNT:
  - dec_ena=1, dec_rdforce=0.
  - comma → ACQ with acq_cnt=1.
  - If ACQ_COMMAS==1, comma → SYNC directly.
- ACQ:
  - comma → acq_cnt+1; when the new count equals ACQ_COMMAS → SYNC.
  - good non-comma → hold; acq_cnt unchanged.
  - err word → HUNT, acq_cnt=0, err_cnt+1.
- SYNC:
  - sync=1 from the entry edge.
  - On entry, bad_cnt=0 and good_cnt=0.
  - err word: bad_cnt+1, good_cnt=0, err_cnt+1.
    - If the new bad_cnt equals LOSE_ERRS → HUNT, sync=0, sync_lost=1 for one cycle, and all counters cleared except err_cnt.
  - good word: good_cnt+1.
    - When the new good_cnt equals GOOD_WORDS: good_cnt=0, and bad_cnt−1 if bad_cnt>0.
    - With bad_cnt=0, good_cnt still wraps to 0.
- link_en=0 in any non-IDLE state → IDLE at the next edge.
  - Outputs take their IDLE values.
  - No sync_lost pulse.
  - err_cnt is retained.
  - The link_en=0 check has priority over word-class transitions.
- err_cnt:
  - Increments only in ACQ/SYNC; err words in HUNT are not counted.
  - Saturates at 2^ERR_W−1.
  - err_clr=1 sets it to 0 and wins over a same-cycle increment.

Test Plan:
- Bring-up: reset_n=0 for 10 cycles, then 1, then link_en=1 → check the sequence below.
  - state: IDLE→FORCE; dec_rdforce=1 for exactly 2 cycles with dec_rdin=0; then HUNT with dec_ena=1.
- Acquisition: in HUNT, drive 3 valid K28.5 words (kout=1, dataout=8'hBC), interleaved with dec_valid=0 gaps and one good data word 8'h4A.
  - sync rises on the edge sampling the 3rd comma; state=4.
- Acquire abort: 2 commas, then one word with kerr=1 → state=2 (HUNT), err_cnt=1, sync stays 0.
- Loss of sync from SYNC: drive err, err, good×4, err, err, err.
  - bad_cnt goes 1,2, drops to 1 after the 4 good words, then reaches 4.
  - sync_lost pulses for one cycle and state=2 on the last err.
  - err_cnt has increased by 5.
- Counter edges (ERR_W=4):
  - 20 error words in ACQ/SYNC → err_cnt holds at 4'hF.
  - err_clr asserted on the same cycle as an error word → err_cnt=0.
- Abort: link_en=0 while in SYNC → IDLE the next cycle, all outputs 0, no sync_lost pulse, err_cnt unchanged.
  - reset_n=0 mid-FORCE → IDLE with all outputs at reset values at that edge.
